vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA timing block. Timing is fully parametrised: porches, sync widths, sync polarity, pixel clock divider and framebuffer read latency. It issues pixel fetch coordinates to a framebuffer and accepts colour returned FB_LATENCY pixel ticks later. It delays sync/active to match, so colour, syncs and active always leave the block aligned.

---
 rtl/vga_timing_gen_pkg.sv | 32 +++
 rtl/vga_timing_gen_if.sv | 45 ++++
 rtl/vga_delay_line.sv | 25 ++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing types, 640x480@60 defaults and test-pattern codes.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
        v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33}
    };

    typedef enum logic [1:0] {
        PAT_FB      = 2'b00,
        PAT_BARS    = 2'b01,
        PAT_CHECKER = 2'b10,
        PAT_WHITE   = 2'b11
    } pattern_e;

    function automatic int axis_total(input vga_axis_t a);
        return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Request/framebuffer/pin bundle of the VGA timing generator.
// pattern_sel exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
    parameter int PIXEL_BITS = 4,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9
);
    logic                  pix_tick;
    logic                  req_valid;
    logic [X_BITS-1:0]     req_x;
    logic [Y_BITS-1:0]     req_y;
    logic [PIXEL_BITS-1:0] fb_r, fb_g, fb_b;
    logic [PIXEL_BITS-1:0] vga_r, vga_g, vga_b;
    logic                  h_sync, v_sync, vga_active;
    logic                  line_start, frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic [1:0]            pattern_sel;

    modport master (
        output pix_tick, req_valid, req_x, req_y,
        output vga_r, vga_g, vga_b, h_sync, v_sync, vga_active,
        output line_start, frame_start,
        input  fb_r, fb_g, fb_b, pattern_sel
    );
    modport slave (
        input  pix_tick, req_valid, req_x, req_y,
        input  vga_r, vga_g, vga_b, h_sync, v_sync, vga_active,
        input  line_start, frame_start,
        output fb_r, fb_g, fb_b, pattern_sel
    );
`else
    modport master (
        output pix_tick, req_valid, req_x, req_y,
        output vga_r, vga_g, vga_b, h_sync, v_sync, vga_active,
        output line_start, frame_start,
        input  fb_r, fb_g, fb_b
    );
    modport slave (
        input  pix_tick, req_valid, req_x, req_y,
        input  vga_r, vga_g, vga_b, h_sync, v_sync, vga_active,
        input  line_start, frame_start,
        output fb_r, fb_g, fb_b
    );
`endif
endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages with a synchronous reset value.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel divider, h/v counters, framebuffer
// requests and a latency-matched output stage. Optional VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIXEL_BITS = 4,
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = int'(VGA_640X480.h.active),
    parameter int H_FP       = int'(VGA_640X480.h.fp),
    parameter int H_SYNC     = int'(VGA_640X480.h.sync),
    parameter int H_BP       = int'(VGA_640X480.h.bp),
    parameter int V_ACTIVE   = int'(VGA_640X480.v.active),
    parameter int V_FP       = int'(VGA_640X480.v.fp),
    parameter int V_SYNC     = int'(VGA_640X480.v.sync),
    parameter int V_BP       = int'(VGA_640X480.v.bp),
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int FB_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    vga_timing_gen_if.master bus
);
    localparam vga_timing_t TIM = '{
        h: '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)},
        v: '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)}
    };
    localparam int H_TOTAL = axis_total(TIM.h);
    localparam int V_TOTAL = axis_total(TIM.v);
    localparam int HC_W    = $clog2(H_TOTAL + 1);
    localparam int VC_W    = $clog2(V_TOTAL + 1);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int X_BITS  = $clog2(H_ACTIVE);
    localparam int Y_BITS  = $clog2(V_ACTIVE);
    localparam int RGB_W   = 3 * PIXEL_BITS;
    localparam logic HS_ON = (H_SYNC_POL != 0);
    localparam logic VS_ON = (V_SYNC_POL != 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [HC_W-1:0]  h_q, h_d;
    logic [VC_W-1:0]  v_q, v_d;

    always_comb begin
        tick_d = (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = tick_d ? '0 : div_q + 1'b1;
        h_d    = h_q;
        v_d    = v_q;
        if (tick_q) begin
            if (h_q == HC_W'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == VC_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
        end
    end

    logic h_act, v_act, raw_hs, raw_vs, req_valid;

    assign h_act     = h_q < HC_W'(H_ACTIVE);
    assign v_act     = v_q < VC_W'(V_ACTIVE);
    assign raw_hs    = (h_q >= HC_W'(H_ACTIVE + H_FP)) && (h_q < HC_W'(H_ACTIVE + H_FP + H_SYNC));
    assign raw_vs    = (v_q >= VC_W'(V_ACTIVE + V_FP)) && (v_q < VC_W'(V_ACTIVE + V_FP + V_SYNC));
    assign req_valid = h_act && v_act;

    assign bus.pix_tick    = tick_q;
    assign bus.req_valid   = req_valid;
    assign bus.req_x       = req_valid ? h_q[X_BITS-1:0] : '0;
    assign bus.req_y       = req_valid ? v_q[Y_BITS-1:0] : '0;
    assign bus.frame_start = tick_q && (h_q == '0) && (v_q == '0);
    assign bus.line_start  = tick_q && (h_q == '0) && v_act;

    // Flags travel the same FB_LATENCY ticks as the framebuffer read.
    logic [2:0] flags_dly;

    vga_delay_line #(.WIDTH(3), .DEPTH(FB_LATENCY)) u_flag_dly (
        .clk  (clk),
        .rst  (rst),
        .en_i (tick_q),
        .d_i  ({req_valid, raw_hs, raw_vs}),
        .q_o  (flags_dly)
    );

    logic [RGB_W-1:0] src_rgb;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [15:0]      px, py;
    logic [2:0]       bar_idx;
    logic [RGB_W-1:0] pat_rgb;
    logic [RGB_W+1:0] pat_dly;

    always_comb begin
        px      = 16'(h_q);
        py      = 16'(v_q);
        bar_idx = 3'(px / 16'(BAR_W));
        pat_rgb = '0;
        case (pattern_e'(bus.pattern_sel))
            PAT_BARS:    pat_rgb = {{PIXEL_BITS{bar_idx[2]}}, {PIXEL_BITS{bar_idx[1]}},
                                    {PIXEL_BITS{bar_idx[0]}}};
            PAT_CHECKER: pat_rgb = {RGB_W{((px ^ py) & 16'h0020) != 16'h0000}};
            PAT_WHITE:   pat_rgb = '1;
            default:     pat_rgb = '0;
        endcase
    end

    // The selector rides with the pattern so a mid-frame switch stays aligned.
    vga_delay_line #(.WIDTH(RGB_W + 2), .DEPTH(FB_LATENCY)) u_pat_dly (
        .clk  (clk),
        .rst  (rst),
        .en_i (tick_q),
        .d_i  ({bus.pattern_sel, pat_rgb}),
        .q_o  (pat_dly)
    );

    assign src_rgb = (pat_dly[RGB_W+1:RGB_W] == PAT_FB) ? {bus.fb_r, bus.fb_g, bus.fb_b}
                                                        : pat_dly[RGB_W-1:0];
`else
    assign src_rgb = {bus.fb_r, bus.fb_g, bus.fb_b};
`endif

    logic [RGB_W-1:0] rgb_q;
    logic             active_q, hs_q, vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q    <= '0;
            active_q <= 1'b0;
            hs_q     <= !HS_ON;
            vs_q     <= !VS_ON;
        end else if (tick_q) begin
            rgb_q    <= flags_dly[2] ? src_rgb : '0;
            active_q <= flags_dly[2];
            hs_q     <= flags_dly[1] ? HS_ON : !HS_ON;
            vs_q     <= flags_dly[0] ? VS_ON : !VS_ON;
        end
    end

    assign bus.vga_r      = rgb_q[3*PIXEL_BITS-1:2*PIXEL_BITS];
    assign bus.vga_g      = rgb_q[2*PIXEL_BITS-1:PIXEL_BITS];
    assign bus.vga_b      = rgb_q[PIXEL_BITS-1:0];
    assign bus.vga_active = active_q;
    assign bus.h_sync     = hs_q;
    assign bus.v_sync     = vs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: 640x480 timing with FB_LATENCY=2 (dut_a) and a tiny
// 7x5 raster with CLK_DIV=1, positive h_sync (dut_b).
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.PIXEL_BITS(4), .X_BITS(10), .Y_BITS(9)) a_if ();
    vga_timing_gen_if #(.PIXEL_BITS(4), .X_BITS(2),  .Y_BITS(1)) b_if ();

    vga_timing_gen #(.FB_LATENCY(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_SYNC_POL(1)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if)
    );

    logic [3:0] fba0 = '0, fba1 = '0;
    logic [3:0] fbb_r = '0, fbb_g = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk; framebuffer models register the request seen on each pix_tick.
    task automatic step();
        logic       ta, tbt;
        logic [9:0] xa;
        logic [1:0] xb;
        logic       yb;
        ta  = a_if.pix_tick;
        xa  = a_if.req_x;
        tbt = b_if.pix_tick;
        xb  = b_if.req_x;
        yb  = b_if.req_y;
        @(posedge clk);
        #1;
        cyc++;
        if (ta) begin
            fba1 = fba0;
            fba0 = xa[3:0];
        end
        if (tbt) begin
            fbb_r = {2'b00, xb};
            fbb_g = {3'b000, yb};
        end
        a_if.fb_r = fba1;
        a_if.fb_g = 4'h0;
        a_if.fb_b = 4'h0;
        b_if.fb_r = fbb_r;
        b_if.fb_g = fbb_g;
        b_if.fb_b = 4'hA;
    endtask

    task automatic next_tick_a(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!a_if.pix_tick && k < 8);
        if (!a_if.pix_tick) chk(tag, a_if.pix_tick, 1);
    endtask

    initial begin
        int act_cnt, hs_cnt, hs_first, ls_cnt, bad_r, bad_act, bad_vs, c0;
        int bad_b, b_hs, b_vs, b_act, b_ls, b_fs, b_fs2, b_tk;
        logic [3:0] er, eg, eb;
        logic       eact, ehs, evs, pat;

        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.fb_r = '0; a_if.fb_g = '0; a_if.fb_b = '0;
        b_if.fb_r = '0; b_if.fb_g = '0; b_if.fb_b = '0;
`ifdef VGA_TEST_PATTERN_EN
        a_if.pattern_sel = 2'b00;
        b_if.pattern_sel = 2'b11;
        pat = 1'b1;
`else
        pat = 1'b0;
`endif
        repeat (5) step();

        chk("a_rst_tick",   a_if.pix_tick, 0);
        chk("a_rst_fs",     a_if.frame_start, 0);
        chk("a_rst_ls",     a_if.line_start, 0);
        chk("a_rst_hs",     a_if.h_sync, 1);
        chk("a_rst_vs",     a_if.v_sync, 1);
        chk("a_rst_active", a_if.vga_active, 0);
        chk("a_rst_rgb",    {a_if.vga_r, a_if.vga_g, a_if.vga_b}, 0);
        chk("b_rst_hs",     b_if.h_sync, 0);
        chk("b_rst_vs",     b_if.v_sync, 1);

        rst_a = 1'b0;
        step();
        chk("a_tick_clk1", a_if.pix_tick, 0);
        step();
        chk("a_tick_clk2", a_if.pix_tick, 1);
        chk("a_fs_clk2",   a_if.frame_start, 1);
        chk("a_ls_clk2",   a_if.line_start, 1);
        chk("a_rv_clk2",   a_if.req_valid, 1);
        chk("a_rx_clk2",   a_if.req_x, 0);

        // One line: pins lag requests by FB_LATENCY+1 = 3 ticks.
        act_cnt = 0; hs_cnt = 0; hs_first = -1; ls_cnt = 0;
        bad_r = 0; bad_act = 0; bad_vs = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) next_tick_a("a_line_tick_timeout");
            if (a_if.vga_active !== (i >= 3 && i < 643)) bad_act++;
            if (a_if.vga_active === 1'b1) begin
                act_cnt++;
                if (a_if.vga_r !== 4'((i - 3) % 16)) bad_r++;
            end else if (a_if.vga_r !== 4'h0) begin
                bad_r++;
            end
            if (a_if.h_sync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (a_if.line_start === 1'b1) ls_cnt++;
            if (a_if.v_sync !== 1'b1) bad_vs++;
        end
        chk("a_active_cnt",    act_cnt, 640);
        chk("a_active_window", bad_act, 0);
        chk("a_hs_low_cnt",    hs_cnt, 96);
        chk("a_hs_start",      hs_first - 3, 656);
        chk("a_rgb_pixels",    bad_r, 0);
        chk("a_ls_per_line",   ls_cnt, 1);
        chk("a_vs_line0",      bad_vs, 0);

        next_tick_a("a_l1_tick_timeout");
        chk("a_l1_ls",     a_if.line_start, 1);
        chk("a_l1_fs",     a_if.frame_start, 0);
        chk("a_l1_ry",     a_if.req_y, 1);
        chk("a_l1_rx",     a_if.req_x, 0);
        chk("a_l1_active", a_if.vga_active, 0);

        for (int i = 0; i < 300; i++) next_tick_a("a_mid_tick_timeout");
        chk("a_mid_rx",     a_if.req_x, 300);
        chk("a_mid_ry",     a_if.req_y, 1);
        chk("a_mid_active", a_if.vga_active, 1);
        chk("a_mid_r",      a_if.vga_r, 9);

        // Single-clk reset in the middle of an active line.
        rst_a = 1'b1;
        step();
        chk("a_mrst_active", a_if.vga_active, 0);
        chk("a_mrst_rgb",    {a_if.vga_r, a_if.vga_g, a_if.vga_b}, 0);
        chk("a_mrst_hs",     a_if.h_sync, 1);
        chk("a_mrst_vs",     a_if.v_sync, 1);
        chk("a_mrst_tick",   a_if.pix_tick, 0);
        chk("a_mrst_rx",     a_if.req_x, 0);
        rst_a = 1'b0;
        c0 = cyc;
        next_tick_a("a_rel_tick_timeout");
        chk("a_rel_latency", cyc - c0, 2);
        chk("a_rel_fs",      a_if.frame_start, 1);
        chk("a_rel_active",  a_if.vga_active, 0);
        chk("a_rel_r",       a_if.vga_r, 0);
        for (int j = 1; j <= 3; j++) begin
            next_tick_a("a_rel_tick_timeout");
            chk("a_rel_pipe_active", a_if.vga_active, (j == 3) ? 1 : 0);
            chk("a_rel_pipe_r",      a_if.vga_r, 0);
        end

        // Tiny raster: H_TOTAL 7, V_TOTAL 5, pins lag 2 ticks.
        rst_b = 1'b0;
        bad_b = 0; b_hs = 0; b_vs = 0; b_act = 0; b_ls = 0; b_fs = 0; b_fs2 = -1; b_tk = 0;
        for (int i = 0; i < 70; i++) begin
            int r, hh, vv;
            step();
            if (b_if.pix_tick === 1'b1) b_tk++;
            if (b_if.frame_start === 1'b1) begin
                b_fs++;
                if (i > 0 && b_fs2 < 0) b_fs2 = i;
            end
            if (i < 35 && b_if.line_start === 1'b1) b_ls++;
            if (i < 2) begin
                eact = 1'b0; ehs = 1'b0; evs = 1'b1; er = '0; eg = '0; eb = '0;
            end else begin
                r    = i - 2;
                hh   = r % 7;
                vv   = (r / 7) % 5;
                eact = (hh < 4) && (vv < 2);
                ehs  = (hh == 5);
                evs  = (vv != 3);
                er   = !eact ? 4'h0 : pat ? 4'hF : 4'(hh);
                eg   = !eact ? 4'h0 : pat ? 4'hF : 4'(vv);
                eb   = !eact ? 4'h0 : pat ? 4'hF : 4'hA;
            end
            if ({b_if.vga_active, b_if.h_sync, b_if.v_sync, b_if.vga_r, b_if.vga_g, b_if.vga_b}
                !== {eact, ehs, evs, er, eg, eb}) bad_b++;
            if (i >= 2 && i < 37) begin
                if (b_if.h_sync === 1'b1) b_hs++;
                if (b_if.v_sync === 1'b0) b_vs++;
                if (b_if.vga_active === 1'b1) b_act++;
            end
        end
        chk("b_pixels",      bad_b, 0);
        chk("b_tick_cnt",    b_tk, 70);
        chk("b_hs_high_cnt", b_hs, 5);
        chk("b_vs_low_cnt",  b_vs, 7);
        chk("b_active_cnt",  b_act, 8);
        chk("b_ls_cnt",      b_ls, 2);
        chk("b_fs_cnt",      b_fs, 2);
        chk("b_fs_period",   b_fs2, 35);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
